bcd_down_counter: RTL and testbench
===================================

# bcd_down_counter

Synchronous multi-digit decade (BCD) down counter with parallel load, count enable, zero flag and cascadable borrow output. It mirrors the team's mod-10 up counter: it counts in the opposite direction, and it is fully synchronous rather than ripple-clocked. It is intended for countdown timers and for dividers feeding the display and timing blocks. Instances cascade through `borrow` into the next instance's `enable`.

## Interface
Parameters:
- `DIGITS`, default 2: number of BCD digits; must be 1 or greater.

Ports:
- `clock`, input, 1: single clock. All state changes on its rising edge.
- `clear`, input, 1: asynchronous, active-high reset.
- `enable`, input, 1: count-down request for this cycle.
- `load`, input, 1: synchronous parallel load.
- `load_value`, input, 4*DIGITS: BCD value to load. Digit i is bits [4i+3:4i]; digit 0 is least significant.
- `q`, output, 4*DIGITS: current BCD count.
- `zero`, output, 1: high when every digit of `q` is 0.
- `borrow`, output, 1: high when `enable` is high, `q` is all zeros and `load` is low. Cascade output.

## Operation
- Priority, highest first: `clear`, then `load`, then `enable`, then hold.
- Clear:
  - `q` goes to all zeros immediately, without waiting for a clock edge.
  - State is held at zero while `clear` is high, regardless of `load` or `enable`.
- Load:
  - Each digit takes its `load_value` digit.
  - Non-BCD digit values (0xA to 0xF) are clamped to 9, per digit.
- Count:
  - Digit 0 decrements whenever `enable` is high.
  - Digit i (i > 0) decrements only when `enable` is high and digits 0 to i-1 are all 0.
  - A digit that decrements from 0 wraps to 9.
- Wrap-around: all zeros with `enable` high goes to all nines, e.g. 00 to 99 for `DIGITS` = 2.
- Hold: with `enable` and `load` both low, `q` is unchanged.
- `zero` and `borrow` are combinational decodes of the registered `q` and the current inputs. Both are glitch-free with respect to `q`. `borrow` is forced low while `clear` is high.
- Digits never hold a non-BCD value under any input sequence.

## Timing
- Reset values: `q` = all zeros, `zero` = 1, `borrow` = 0.
- Load latency: 1 cycle. `q` shows the loaded value after the edge on which `load` was sampled high.
- Count latency: 1 cycle per decrement.
- Borrow timing: `borrow` is high during the cycle before the wrap edge (or the hold edge in saturate mode). A downstream instance with `enable` = upstream `borrow` therefore decrements on the same edge that the upstream instance wraps.
- If `load` and `enable` are high together, `load` wins and no decrement occurs.
- Clear released mid-operation: counting resumes from all zeros on the first edge after `clear` falls.

## Configuration
- Macro: `BCD_DOWN_SATURATE_EN`.
- Defined:
  - All zeros with `enable` high holds at all zeros; no wrap.
  - `zero` stays 1.
  - `borrow` still asserts per the rule above, so a terminal-count indication remains available.
- Undefined: wrap-around as described in Operation.

## Structure
- Shared package `bcd_pkg`:
  - `BCD_WIDTH` = 4.
  - `BCD_MAX` = 4'd9.
  - `BCD_ZERO` = 4'd0.
  - BCD clamp function (values above 9 map to 9).
- Sub-module `mod_10_down_digit`:
  - Ports: `clock`, `clear`, `load`, `load_digit`, `dec`, `q_digit`, `digit_zero`.
  - One instance per digit via generate.
  - The top level forms the per-digit `dec` chain and the `zero`/`borrow` decodes.

## Test plan
1. `DIGITS` = 2. Count to 0x37, then pulse `clear` between clock edges. `q` = 0x00 before the next edge, `zero` = 1, `borrow` = 0.
2. Load 0x25, then `enable` for 27 cycles. Sequence is 25, 24, …, 20, 19, …, 01, 00, 99. `borrow` = 1 only in the cycle where `q` = 00. Digit 1 steps only on 20 to 19, 10 to 09, and 00 to 99.
3. Load 0x3C. `q` = 0x39. Load 0xFF gives `q` = 0x99.
4. With `q` = 0x50, hold `load` = 1 (`load_value` = 0x12) and `enable` = 1 together. `q` = 0x12 and no decrement occurs. Then `enable` = 0 for 5 cycles: `q` stays 0x12.
5. Two `DIGITS` = 1 instances cascaded via `borrow` to `enable`, both loaded with 1, then enable the upper stage chain for 3 cycles. Combined value goes 11, 10, 09, 08.
6. With `BCD_DOWN_SATURATE_EN` defined: load 0x02, then `enable` for 6 cycles. Sequence is 02, 01, 00, 00, 00, 00. `zero` = 1 from cycle 2 onward, `borrow` = 1 while at 00.

Source files
------------

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit constants and the non-BCD clamp helper
package bcd_pkg;

  localparam int         BCD_WIDTH = 4;
  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [3:0] BCD_ZERO  = 4'd0;

  // Non-BCD codes 0xA..0xF are pulled back to 9 so a digit can never leave 0..9.
  function automatic logic [BCD_WIDTH-1:0] bcd_clamp(input logic [BCD_WIDTH-1:0] value);
    return (value > BCD_MAX) ? BCD_MAX : value;
  endfunction

endpackage

// File: rtl/mod_10_down_digit.sv
// rtl/mod_10_down_digit.sv - one decade down-counting digit with clamped load and async clear
module mod_10_down_digit
  import bcd_pkg::*;
(
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 load,
  input  logic [BCD_WIDTH-1:0] load_digit,
  input  logic                 dec,
  output logic [BCD_WIDTH-1:0] q_digit,
  output logic                 digit_zero
);

  logic [BCD_WIDTH-1:0] q_digit_q;
  logic [BCD_WIDTH-1:0] q_digit_d;

  // Next digit value: load beats decrement; decrementing from 0 wraps to 9.
  always_comb begin
    q_digit_d = q_digit_q;
    if (load) begin
      q_digit_d = bcd_clamp(load_digit);
    end else if (dec) begin
      q_digit_d = (q_digit_q == BCD_ZERO) ? BCD_MAX : (q_digit_q - 4'd1);
    end
  end

  // Digit register; clear forces zero immediately and holds it there.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      q_digit_q <= BCD_ZERO;
    end else begin
      q_digit_q <= q_digit_d;
    end
  end

  assign q_digit    = q_digit_q;
  assign digit_zero = (q_digit_q == BCD_ZERO);

endmodule

// File: rtl/bcd_down_counter.sv
// rtl/bcd_down_counter.sv - multi-digit BCD down counter, optional hold-at-zero via BCD_DOWN_SATURATE_EN
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   q,
  output logic                  zero,
  output logic                  borrow
);

  // low_zero[i] is high when digits 0..i-1 are all zero; low_zero[DIGITS] covers the whole count.
  logic [DIGITS:0]   low_zero;
  logic [DIGITS-1:0] digit_zero;
  logic [DIGITS-1:0] dec;
  logic              count_ok;

  assign low_zero[0] = 1'b1;

`ifdef BCD_DOWN_SATURATE_EN
  // At all zeros the counter parks instead of wrapping to all nines.
  assign count_ok = enable & ~load & ~low_zero[DIGITS];
`else
  assign count_ok = enable & ~load;
`endif

  genvar i;
  generate
    for (i = 0; i < DIGITS; i++) begin : g_digit
      assign low_zero[i+1] = low_zero[i] & digit_zero[i];
      assign dec[i]        = count_ok & low_zero[i];

      mod_10_down_digit u_digit (
        .clock      (clock),
        .clear      (clear),
        .load       (load),
        .load_digit (load_value[4*i +: 4]),
        .dec        (dec[i]),
        .q_digit    (q[4*i +: 4]),
        .digit_zero (digit_zero[i])
      );
    end
  endgenerate

  // Decodes read only registered digits, so they cannot glitch against q.
  assign zero   = low_zero[DIGITS];
  assign borrow = enable & zero & ~load & ~clear;

endmodule

// File: tb/tb_bcd_down_counter.sv
// tb/tb_bcd_down_counter.sv - directed self-checking bench for bcd_down_counter
module tb_bcd_down_counter;

  logic       clock;
  logic       clear;
  logic       enable;
  logic       load;
  logic [7:0] load_value;
  logic [7:0] q;
  logic       zero;
  logic       borrow;

  logic       en_c;
  logic       load_c;
  logic [3:0] lv_c;
  logic [3:0] q_lo;
  logic [3:0] q_hi;
  logic       zero_lo;
  logic       zero_hi;
  logic       borrow_lo;
  logic       borrow_hi;

  int checks = 0;
  int errors = 0;
  int expv;

  bcd_down_counter #(.DIGITS(2)) dut (
    .clock(clock), .clear(clear), .enable(enable), .load(load),
    .load_value(load_value), .q(q), .zero(zero), .borrow(borrow)
  );

  bcd_down_counter #(.DIGITS(1)) u_lo (
    .clock(clock), .clear(clear), .enable(en_c), .load(load_c),
    .load_value(lv_c), .q(q_lo), .zero(zero_lo), .borrow(borrow_lo)
  );

  bcd_down_counter #(.DIGITS(1)) u_hi (
    .clock(clock), .clear(clear), .enable(borrow_lo), .load(load_c),
    .load_value(lv_c), .q(q_hi), .zero(zero_hi), .borrow(borrow_hi)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  function automatic int next_down(input int v);
`ifdef BCD_DOWN_SATURATE_EN
    return (v == 0) ? 0 : v - 1;
`else
    return (v == 0) ? 99 : v - 1;
`endif
  endfunction

  initial begin
    clear = 1'b1; enable = 1'b1; load = 1'b0; load_value = 8'h00;
    en_c = 1'b0; load_c = 1'b0; lv_c = 4'h0;
    #3;
    check("reset_q", q, 8'h00);
    check("reset_zero", {7'd0, zero}, 8'd1);
    check("reset_borrow", {7'd0, borrow}, 8'd0);
    step();
    clear = 1'b0;

    // 1: count to 37, then clear between edges
    enable = 1'b0; load = 1'b1; load_value = 8'h38;
    step();
    load = 1'b0; enable = 1'b1;
    step();
    check("t1_q37", q, 8'h37);
    #2 clear = 1'b1;
    #1;
    check("t1_clear_q", q, 8'h00);
    check("t1_clear_zero", {7'd0, zero}, 8'd1);
    check("t1_clear_borrow", {7'd0, borrow}, 8'd0);
    load = 1'b1; load_value = 8'h44;
    step();
    check("t1_clear_held", q, 8'h00);
    clear = 1'b0; load = 1'b0; enable = 1'b1;
    #1;
    check("t1_borrow_at_zero", {7'd0, borrow}, 8'd1);
    step();
    check("t1_resume", q, to_bcd(next_down(0)));

    // 2: load 25 and count down 27 cycles
    enable = 1'b0; load = 1'b1; load_value = 8'h25;
    step();
    load = 1'b0; enable = 1'b1;
    expv = 25;
    for (int n = 0; n < 27; n++) begin
      #1;
      check($sformatf("t2_q_%0d", n), q, to_bcd(expv));
      check($sformatf("t2_borrow_%0d", n), {7'd0, borrow}, {7'd0, expv == 0});
      step();
      expv = next_down(expv);
    end
    check("t2_final", q, to_bcd(expv));

    // 3: clamping of non-BCD load digits
    enable = 1'b0; load = 1'b1; load_value = 8'h3C;
    step();
    check("t3_3C", q, 8'h39);
    load_value = 8'hFF;
    step();
    check("t3_FF", q, 8'h99);
    load_value = 8'hA5;
    step();
    check("t3_A5", q, 8'h95);

    // 4: load beats enable, then hold
    load_value = 8'h50;
    step();
    check("t4_q50", q, 8'h50);
    load_value = 8'h12; enable = 1'b1;
    step();
    check("t4_load_wins", q, 8'h12);
    load = 1'b0; enable = 1'b0;
    for (int n = 0; n < 5; n++) step();
    check("t4_hold", q, 8'h12);
    check("t4_hold_borrow", {7'd0, borrow}, 8'd0);

    // 5: cascade of two single-digit instances
    load_c = 1'b1; lv_c = 4'd1;
    step();
    load_c = 1'b0;
    check("t5_q11", {q_hi, q_lo}, 8'h11);
    en_c = 1'b1;
    step();
    check("t5_q10", {q_hi, q_lo}, 8'h10);
    check("t5_borrow_lo", {7'd0, borrow_lo}, 8'd1);
    step();
    check("t5_q09", {q_hi, q_lo}, 8'h09);
    step();
    check("t5_q08", {q_hi, q_lo}, 8'h08);
    check("t5_zero_hi", {7'd0, zero_hi}, 8'd1);
    en_c = 1'b0;

    // 6: terminal behaviour from 02 (wrap or saturate by build)
    enable = 1'b0; load = 1'b1; load_value = 8'h02;
    step();
    load = 1'b0; enable = 1'b1;
    expv = 2;
    for (int n = 0; n < 6; n++) begin
      #1;
      check($sformatf("t6_q_%0d", n), q, to_bcd(expv));
      check($sformatf("t6_zero_%0d", n), {7'd0, zero}, {7'd0, expv == 0});
      check($sformatf("t6_borrow_%0d", n), {7'd0, borrow}, {7'd0, expv == 0});
      step();
      expv = next_down(expv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
